// File: rtl/reg_write_checker.sv
// rtl/reg_write_checker.sv - in-order register-write checker against a preloaded expected queue
// Taps a register-file write port and reports pass, fail class and failing entry.
module reg_write_checker #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int DEPTH      = 16,
   parameter int TIMEOUT    = 64,
   parameter int FILTER     = 1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     load_valid,
   input  logic [ADDR_WIDTH-1:0]    load_address,
   input  logic [DATA_WIDTH-1:0]    load_data,
   input  logic                     start,
   input  logic                     write_enable,
   input  logic [ADDR_WIDTH-1:0]    write_address,
   input  logic [DATA_WIDTH-1:0]    write_data,
   output logic                     full,
   output logic                     overflow,
   output logic                     running,
   output logic                     done,
   output logic                     pass,
   output logic [1:0]               fail_code,
   output logic [$clog2(DEPTH):0]   fail_index,
   output logic [DATA_WIDTH-1:0]    observed_data,
   output logic [$clog2(DEPTH):0]   checked
);

   localparam int IW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TIMEOUT_V = TW'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

   state_t                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  addr_mem_q [DEPTH];
   logic [DATA_WIDTH-1:0]  data_mem_q [DEPTH];
   logic [IW:0]            wptr_q, wptr_d;
   logic [IW:0]            rptr_q, rptr_d;
   logic                   overflow_q, overflow_d;
   logic [IW:0]            checked_q, checked_d;
   logic [TW-1:0]          timer_q, timer_d;
   logic [1:0]             fail_code_q, fail_code_d;
   logic [IW:0]            fail_index_q, fail_index_d;
   logic [DATA_WIDTH-1:0]  observed_q, observed_d;

   logic                   push;
   logic                   q_empty;
   logic                   q_full;
   logic [ADDR_WIDTH-1:0]  head_addr;
   logic [DATA_WIDTH-1:0]  head_data;
   logic                   addr_eq;
   logic                   data_eq;
   logic                   eligible;

   // Pointers carry one extra bit so full and empty are distinguishable.
   assign q_empty   = (wptr_q == rptr_q);
   assign q_full    = (wptr_q[IW] != rptr_q[IW]) && (wptr_q[IW-1:0] == rptr_q[IW-1:0]);
   assign head_addr = addr_mem_q[rptr_q[IW-1:0]];
   assign head_data = data_mem_q[rptr_q[IW-1:0]];
   assign addr_eq   = (write_address == head_addr);
   assign data_eq   = (write_data == head_data);
   assign eligible  = write_enable && (write_address != '0) && ((FILTER == 0) || addr_eq);

   always_comb begin
      state_d      = state_q;
      wptr_d       = wptr_q;
      rptr_d       = rptr_q;
      overflow_d   = overflow_q;
      checked_d    = checked_q;
      timer_d      = timer_q;
      fail_code_d  = fail_code_q;
      fail_index_d = fail_index_q;
      observed_d   = observed_q;
      push         = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (load_valid) begin
               if (q_full) begin
                  overflow_d = 1'b1;
               end else begin
                  push   = 1'b1;
                  wptr_d = wptr_q + 1'b1;
               end
            end
            if (start) begin
               timer_d = '0;
               state_d = q_empty ? PASS : RUN;
            end
         end
         RUN: begin
            // A match outranks the timeout expiring in the same cycle.
            if (eligible && addr_eq && data_eq) begin
               rptr_d    = rptr_q + 1'b1;
               checked_d = checked_q + 1'b1;
               timer_d   = '0;
               if (rptr_d == wptr_q) begin
                  state_d = PASS;
               end
            end else if (eligible) begin
               state_d      = FAIL;
               fail_code_d  = addr_eq ? 2'd1 : 2'd2;
               fail_index_d = checked_q;
               observed_d   = write_data;
            end else if (timer_q == TIMEOUT_V) begin
               state_d      = FAIL;
               fail_code_d  = 2'd3;
               fail_index_d = checked_q;
               observed_d   = '0;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q      <= IDLE;
         wptr_q       <= '0;
         rptr_q       <= '0;
         overflow_q   <= 1'b0;
         checked_q    <= '0;
         timer_q      <= '0;
         fail_code_q  <= 2'd0;
         fail_index_q <= '0;
         observed_q   <= '0;
      end else begin
         state_q      <= state_d;
         wptr_q       <= wptr_d;
         rptr_q       <= rptr_d;
         overflow_q   <= overflow_d;
         checked_q    <= checked_d;
         timer_q      <= timer_d;
         fail_code_q  <= fail_code_d;
         fail_index_q <= fail_index_d;
         observed_q   <= observed_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         addr_mem_q[wptr_q[IW-1:0]] <= load_address;
         data_mem_q[wptr_q[IW-1:0]] <= load_data;
      end
   end

   assign full          = q_full;
   assign overflow      = overflow_q;
   assign running       = (state_q == RUN);
   assign done          = (state_q == PASS) || (state_q == FAIL);
   assign pass          = (state_q == PASS);
   assign fail_code     = fail_code_q;
   assign fail_index    = fail_index_q;
   assign observed_data = observed_q;
   assign checked       = checked_q;

endmodule

// File: tb/tb_reg_write_checker.sv
// tb/tb_reg_write_checker.sv - scoreboard bench for reg_write_checker, FILTER=0 and FILTER=1 side by side
// A queue-based reference model predicts every cycle's outputs; a negedge monitor compares them.
module tb_reg_write_checker;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int DEPTH = 4;
   localparam int TMO = 8;
   localparam int MAX_CYCLES = 20000;

   typedef struct packed {
      logic          full;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } ent_raw_t;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } ent_t;

   typedef struct packed {
      logic          full;
      logic          ovf;
      logic          running;
      logic          done;
      logic          pass;
      logic [1:0]    fc;
      logic [2:0]    fi;
      logic [DW-1:0] obs;
      logic [2:0]    chk;
   } out_t;

   logic          clk;
   logic          rst_n;
   logic          lv;
   logic [AW-1:0] la;
   logic [DW-1:0] ld;
   logic          stt;
   logic          we;
   logic [AW-1:0] wa;
   logic [DW-1:0] wd;

   logic          full_o [2];
   logic          ovf_o [2];
   logic          run_o [2];
   logic          done_o [2];
   logic          pass_o [2];
   logic [1:0]    fc_o [2];
   logic [2:0]    fi_o [2];
   logic [DW-1:0] obs_o [2];
   logic [2:0]    chk_o [2];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   bit finished = 0;

   ent_t          mq [2][$];
   int            st [2];
   int            timer [2];
   bit            ovf [2];
   int            chk [2];
   int            fc [2];
   int            fi [2];
   logic [DW-1:0] obs [2];
   out_t          expq [2][$];

   localparam int S_IDLE = 0, S_RUN = 1, S_PASS = 2, S_FAIL = 3;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      reg_write_checker #(
         .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .TIMEOUT(TMO), .FILTER(g)
      ) u_dut (
         .clock(clk), .reset(rst_n),
         .load_valid(lv), .load_address(la), .load_data(ld),
         .start(stt),
         .write_enable(we), .write_address(wa), .write_data(wd),
         .full(full_o[g]), .overflow(ovf_o[g]), .running(run_o[g]), .done(done_o[g]),
         .pass(pass_o[g]), .fail_code(fc_o[g]), .fail_index(fi_o[g]),
         .observed_data(obs_o[g]), .checked(chk_o[g])
      );
   end

   task automatic do_fail(input int f, input int code, input logic [DW-1:0] o);
      st[f]  = S_FAIL;
      fc[f]  = code;
      fi[f]  = chk[f];
      obs[f] = o;
   endtask

   task automatic step();
      ent_t h;
      int   n;
      bit   elig;
      out_t e;
      for (int f = 0; f < 2; f++) begin
         if (!rst_n) begin
            st[f] = S_IDLE; mq[f].delete(); ovf[f] = 0; chk[f] = 0;
            timer[f] = 0; fc[f] = 0; fi[f] = 0; obs[f] = '0;
         end else if (st[f] == S_IDLE) begin
            n = mq[f].size();
            if (lv) begin
               if (n == DEPTH) ovf[f] = 1;
               else mq[f].push_back('{a: la, d: ld});
            end
            if (stt) begin
               timer[f] = 0;
               st[f] = (n == 0) ? S_PASS : S_RUN;
            end
         end else if (st[f] == S_RUN) begin
            h = mq[f][0];
            elig = we && (wa != 0) && ((f == 0) || (wa == h.a));
            if (elig && wa == h.a && wd == h.d) begin
               void'(mq[f].pop_front());
               chk[f]++;
               timer[f] = 0;
               if (mq[f].size() == 0) st[f] = S_PASS;
            end else if (elig && wa != h.a) do_fail(f, 2, wd);
            else if (elig) do_fail(f, 1, wd);
            else if (timer[f] == TMO) do_fail(f, 3, '0);
            else timer[f]++;
         end
         e.full    = (mq[f].size() == DEPTH);
         e.ovf     = ovf[f];
         e.running = (st[f] == S_RUN);
         e.done    = (st[f] == S_PASS) || (st[f] == S_FAIL);
         e.pass    = (st[f] == S_PASS);
         e.fc      = 2'(fc[f]);
         e.fi      = 3'(fi[f]);
         e.obs     = obs[f];
         e.chk     = 3'(chk[f]);
         expq[f].push_back(e);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1; lv = 1'b0; stt = 1'b0; we = 1'b0;
   endtask

   always @(negedge clk) begin
      out_t a, e;
      cyc++;
      for (int f = 0; f < 2; f++) begin
         if (expq[f].size() > 0) begin
            e = expq[f].pop_front();
            a = '{full: full_o[f], ovf: ovf_o[f], running: run_o[f], done: done_o[f],
                  pass: pass_o[f], fc: fc_o[f], fi: fi_o[f], obs: obs_o[f], chk: chk_o[f]};
            checks++;
            if (a !== e) begin
               failures++;
               $display("FAIL outputs filter=%0d cycle=%0d actual=%h required=%h", f, cyc, a, e);
            end
         end
      end
   end

   initial begin
      repeat (MAX_CYCLES) @(posedge clk);
      checks++;
      if (!finished) begin
         failures++;
         $display("FAIL watchdog expired after %0d cycles", MAX_CYCLES);
         $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
         $finish;
      end
   end

   task automatic check_reset_state();
      out_t a;
      for (int f = 0; f < 2; f++) begin
         a = '{full: full_o[f], ovf: ovf_o[f], running: run_o[f], done: done_o[f],
               pass: pass_o[f], fc: fc_o[f], fi: fi_o[f], obs: obs_o[f], chk: chk_o[f]};
         checks++;
         if (a !== '0) begin
            failures++;
            $display("FAIL reset state filter=%0d cycle=%0d actual=%h required=0", f, cyc, a);
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask
   task automatic do_reset();
      rst_n = 1'b0; step();
      check_reset_state();
   endtask
   task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
      lv = 1'b1; la = a; ld = d; step();
   endtask
   task automatic go();
      stt = 1'b1; step();
   endtask
   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      we = 1'b1; wa = a; wd = d; step();
   endtask
   task automatic load_fwd();
      load(5'd5, 32'h0000_1100); load(5'd5, 32'h0000_1120);
      load(5'd5, 32'h0000_5520); load(5'd5, 32'h0000_5564);
   endtask

   initial begin
      rst_n = 1'b0; lv = 1'b0; la = '0; ld = '0; stt = 1'b0; we = 1'b0; wa = '0; wd = '0;
      do_reset();
      idle(2);

      load_fwd(); go();
      wr(5'd5, 32'h0000_1100); wr(5'd3, 32'h0000_0033);
      wr(5'd5, 32'h0000_1120); wr(5'd3, 32'h0000_0034);
      wr(5'd5, 32'h0000_5520); wr(5'd3, 32'h0000_0035);
      wr(5'd5, 32'h0000_5564);
      go(); idle(2);

      do_reset(); load_fwd(); go();
      wr(5'd5, 32'h0000_1100); wr(5'd5, 32'h0000_1120); wr(5'd5, 32'h0000_5521);
      idle(2);

      do_reset(); load(5'd5, 32'h0000_1100); go();
      wr(5'd0, 32'h0000_1100); wr(5'd0, 32'hDEAD_BEEF);
      wr(5'd6, 32'h0000_1100); idle(2);

      do_reset(); load(5'd7, 32'h1234_5678); go();
      idle(TMO + 3);

      do_reset(); load(5'd7, 32'h1111_1111); load(5'd8, 32'h2222_2222); go();
      idle(TMO); wr(5'd7, 32'h1111_1111);
      idle(TMO); wr(5'd8, 32'h2222_2222); idle(2);

      do_reset();
      for (int i = 0; i < 5; i++) load(5'(i + 1), 32'hA000_0000 + 32'(i));
      idle(1);
      do_reset(); go(); idle(2);

      do_reset(); load_fwd(); go();
      wr(5'd5, 32'h0000_1100); wr(5'd5, 32'h0000_1120);
      do_reset(); idle(1);
      load(5'd9, 32'h0000_0099); load(5'd10, 32'h0000_00AA); go();
      wr(5'd9, 32'h0000_0099); wr(5'd10, 32'h0000_00AA); idle(1);

      for (int t = 0; t < 30; t++) begin
         int nl;
         do_reset();
         nl = $urandom_range(1, DEPTH + 1);
         for (int i = 0; i < nl; i++)
            load(5'($urandom_range(1, 7)), 32'($urandom_range(0, 3)));
         go();
         for (int c = 0; c < 30; c++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 50 && mq[1].size() > 0) begin
               if ($urandom_range(0, 9) == 0) wr(mq[1][0].a, mq[1][0].d ^ 32'h1);
               else wr(mq[1][0].a, mq[1][0].d);
            end else if (r < 80) begin
               wr(5'($urandom_range(0, 7)), 32'($urandom_range(0, 3)));
            end else begin
               idle(1);
            end
         end
      end

      idle(1);
      @(negedge clk);
      #1;
      finished = 1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reg_write_checker.md
# reg_write_checker

Self-checking monitor for CPU test benches and FPGA bring-up. It taps the register-file write port and compares every architectural register write against a preloaded queue of expected (address, data) pairs, in order. It replaces fixed-delay register probes with an event-driven, parametrised checker that reports pass/fail, a failure class and the failing entry. It sits beside `sopc`, observing the write port of the CPU register file and driving no CPU signals.

## Interface
- `DATA_WIDTH`, 32, register data width
- `ADDR_WIDTH`, 5, register address width
- `DEPTH`, 16, expected-queue entries; power of two, ≥2
- `TIMEOUT`, 64, maximum RUN cycles allowed between matches; ≥1
- `FILTER`, 1, 1: compare only writes whose address equals the head entry's address; 0: compare every non-zero-address write
- `clock` in 1 — sole clock; all logic on rising edge
- `reset` in 1 — synchronous, active-low
- `load_valid` in 1 — push (`load_address`, `load_data`) into the queue
- `load_address` in ADDR_WIDTH — expected register index
- `load_data` in DATA_WIDTH — expected value
- `start` in 1 — single-cycle pulse that begins checking
- `write_enable` in 1 — register-file write strobe (tapped)
- `write_address` in ADDR_WIDTH — tapped write index
- `write_data` in DATA_WIDTH — tapped write value
- `full` out 1 — queue holds DEPTH entries
- `overflow` out 1 — sticky; a load was dropped
- `running` out 1 — state is RUN
- `done` out 1 — state is PASS or FAIL
- `pass` out 1 — state is PASS
- `fail_code` out 2 — 0 none, 1 data mismatch, 2 address mismatch, 3 timeout
- `fail_index` out log2(DEPTH)+1 — index of the head entry at failure
- `observed_data` out DATA_WIDTH — `write_data` that caused the failure
- `checked` out log2(DEPTH)+1 — entries matched so far

## Operation
- States: IDLE, RUN, PASS, FAIL. Reset (`reset`=0 at an edge) forces IDLE, empties the queue, and zeroes every output, including `overflow`, `checked`, `fail_code`, `fail_index` and `observed_data`.
- IDLE: `load_valid` pushes at the tail. A push while `full` is dropped and sets `overflow`. `start` moves to RUN, or directly to PASS when the queue is empty. `write_enable` is ignored.
- RUN: `load_valid` and `start` are ignored. A write is *eligible* when `write_enable`=1, `write_address`≠0, and (FILTER=0, or `write_address` equals the head address).
- Eligible write, address and data both equal the head: pop the head and increment `checked`. If this was the last entry, go to PASS.
- FILTER=0, eligible write, address differs from the head: go to FAIL with `fail_code`=2.
- Eligible write, address equal, data differs: go to FAIL with `fail_code`=1.
- On any FAIL, capture `fail_index`=`checked` and `observed_data`=`write_data`. A timeout failure captures `observed_data`=0.
- Writes to address 0 are never eligible, matching MIPS `$zero`.
- Timeout counter: cleared on `start` and on each match; increments on every other RUN cycle. When it reaches TIMEOUT, go to FAIL with `fail_code`=3.
- PASS and FAIL hold until reset. `start` in these states is ignored.
- Matched entries are not recoverable; a rerun requires reset and reload.

## Timing
- Push visible on `full` the cycle after the `load_valid` edge.
- `start` sampled at edge N: `running`=1 from N+1. With an empty queue, `done`=`pass`=1 from N+1 instead.
- Write sampled at edge N: `checked` updates, `done` rises and `fail_*` are valid from N+1. There is one verdict per cycle, with no back-pressure.
- Timeout: with no match after the `start` edge, FAIL is visible exactly TIMEOUT+1 cycles after `start` was sampled.
- Simultaneous match and counter reaching TIMEOUT in the same cycle: the match wins and the counter clears.
- `reset`=0 in any state returns to IDLE at that edge and overrides `start` and `load_valid`.
- Queue pointers wrap modulo DEPTH; full and empty are distinguished by an extra pointer bit.

## Test plan
- Forwarding sequence: load four reg-5 entries 0x00001100, 0x00001120, 0x00005520, 0x00005564; drive those writes in consecutive cycles, interleaved with writes to reg 3 → `pass`=1 and `checked`=4 one cycle after the last write.
- Data mismatch: same load; third write is reg 5 = 0x00005521 → `fail_code`=1, `fail_index`=2, `observed_data`=0x00005521.
- FILTER=0 address mismatch: expect reg 5; write reg 6 = 0x00001100 → `fail_code`=2, `fail_index`=0. Writes to reg 0 beforehand are ignored.
- Timeout: TIMEOUT=8, one entry loaded, no writes after `start` → FAIL with `fail_code`=3 exactly 9 cycles after `start` was sampled. Also drive a match on the cycle the counter reaches TIMEOUT → no FAIL and counter cleared.
- Overflow and empty: DEPTH=4, push 5 entries → `full`=1 and `overflow`=1 with 4 entries kept. Reset, then `start` with an empty queue → `pass`=1 one cycle later.
- Reset mid-RUN after 2 matches → all outputs 0 and state IDLE on the next cycle; a fresh load and run passes.
